// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// response-status record used by initiators and decoders on this bus.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;
  localparam int unsigned APB_STB_WIDTH  = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic err;
    logic timeout;
  } apb_status_t;

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: a valid/ready command becomes one APB
// setup/access pair, and its status/read data come back on a valid/ready port.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned TO_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rts_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_stb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstb,
  input  logic                    pready,
  input  logic                    perr
);

  // Last ACCESS count before abort; unused when TIMEOUT is 0.
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);

  apb_state_e            state;
  logic [TO_WIDTH-1:0]   to_cnt;
  apb_status_t           status;

  assign rsp_err     = status.err;
  assign rsp_timeout = status.timeout;

  always_ff @(posedge clk) begin
    if (!rts_n) begin
      state     <= ST_IDLE;
      to_cnt    <= '0;
      status    <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      paddr     <= '0;
      pdata     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pstb      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            paddr     <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
            pwrite    <= cmd_write;
            pstb      <= cmd_write ? cmd_stb : '0;
            pdata     <= cmd_write ? cmd_wdata : '0;
            state     <= ST_SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready is checked first so it wins on the timeout cycle.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            status    <= '{err: perr, timeout: 1'b0};
            state     <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
            if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
              psel      <= 1'b0;
              penable   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              status    <= '{err: 1'b1, timeout: 1'b1};
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            to_cnt    <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed vector table, reset corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_apb_initiator;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rts_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_stb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [31:0] pdata;
  logic [31:0] prdata = '0;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        pready = 1'b0;
  logic        perr = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  apb_initiator #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(TO),
    .TO_WIDTH(16)
  ) dut (
    .clk(clk), .rts_n(rts_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_stb(cmd_stb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pstb(pstb),
    .pready(pready), .perr(perr)
  );

  typedef struct {
    logic [31:0] paddr;
    logic [3:0]  pstb;
    logic [31:0] pdata;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int unsigned acc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  stb;
    int unsigned waits;
    logic        err;
    logic [31:0] rdata;
    int unsigned delay;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic        got;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [3:0]  pstb;
    logic        pwrite;
    int unsigned setup;
    int unsigned acc;
    int unsigned lat;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    logic        bus_unstable;
    logic        bp_bad;
    logic        done_ok;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: waits = pready-low ACCESS cycles before pready.
  function automatic exp_t model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] stb, input int unsigned waits,
                                 input logic err, input logic [31:0] rdata);
    exp_t e;
    logic timed_out;
    timed_out = (waits >= TO);
    e.paddr = addr & 32'hFFFF_FFFC;
    e.pstb  = wr ? stb : 4'h0;
    e.pdata = wr ? wdata : 32'h0;
    e.acc   = timed_out ? TO : waits + 1;
    e.err   = timed_out | err;
    e.to    = timed_out;
    e.rdata = (wr || timed_out) ? 32'h0 : rdata;
    return e;
  endfunction

  // Entered and left at a falling edge; plays both requester and APB slave.
  task automatic run_txn(input vec_t v, output obs_t o);
    int unsigned n;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_to;
    logic        seen;
    o = '{default: '0};
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_stb   = v.stb;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    o.got = cmd_ready;
    if (!o.got) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_stb   = 4'($urandom);
    o.lat = 1;
    seen = 1'b0;
    while (!rsp_valid && o.lat < 64) begin
      if (psel) begin
        if (!seen) begin
          seen     = 1'b1;
          o.paddr  = paddr;
          o.pdata  = pdata;
          o.pstb   = pstb;
          o.pwrite = pwrite;
        end else if (paddr !== o.paddr || pdata !== o.pdata ||
                     pstb !== o.pstb || pwrite !== o.pwrite) begin
          o.bus_unstable = 1'b1;
        end
      end
      if (psel && !penable) o.setup++;
      if (psel && penable) begin
        o.acc++;
        pready = (o.acc > v.waits);
        perr   = pready ? v.err : 1'b1;
        prdata = pready ? v.rdata : $urandom;
      end else begin
        pready = 1'b0;
        perr   = 1'b0;
      end
      @(negedge clk);
      o.lat++;
    end
    pready = 1'b0;
    perr   = 1'b0;
    o.rdata = rsp_rdata;
    o.err   = rsp_err;
    o.to    = rsp_timeout;
    r_rdata = rsp_rdata;
    r_err   = rsp_err;
    r_to    = rsp_timeout;
    if (psel || penable || cmd_ready) o.bp_bad = 1'b1;
    for (int i = 0; i < int'(v.delay); i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== r_rdata || rsp_err !== r_err ||
          rsp_timeout !== r_to || psel || penable || cmd_ready)
        o.bp_bad = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    o.done_ok = cmd_ready && !rsp_valid;
  endtask

  task automatic do_and_check(input string tag, input vec_t v);
    obs_t o;
    run_txn(v, o);
    check({tag, " accept"}, 32'(o.got), 32'd1);
    if (!o.got) return;
    check({tag, " paddr"}, o.paddr, v.e.paddr);
    check({tag, " pstb"}, 32'(o.pstb), 32'(v.e.pstb));
    check({tag, " pdata"}, o.pdata, v.e.pdata);
    check({tag, " pwrite"}, 32'(o.pwrite), 32'(v.wr));
    check({tag, " setup_cycles"}, o.setup, 32'd1);
    check({tag, " access_cycles"}, o.acc, v.e.acc);
    check({tag, " rsp_latency"}, o.lat, v.e.acc + 2);
    check({tag, " rsp_rdata"}, o.rdata, v.e.rdata);
    check({tag, " rsp_err"}, 32'(o.err), 32'(v.e.err));
    check({tag, " rsp_timeout"}, 32'(o.to), 32'(v.e.to));
    check({tag, " bus_stable"}, 32'(o.bus_unstable), 32'd0);
    check({tag, " rsp_hold"}, 32'(o.bp_bad), 32'd0);
    check({tag, " cmd_ready_back"}, 32'(o.done_ok), 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'hAAAA_AAAA, 0,
                '{32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1}};
    vecs[1] = '{1'b0, 32'h8000_0013, 32'h5555_5555, 4'hF, 3, 1'b0, 32'h1234_5678, 0,
                '{32'h8000_0010, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 4}};
    vecs[2] = '{1'b0, 32'h4000_0004, 32'h0, 4'h0, 0, 1'b1, 32'h0000_0055, 1,
                '{32'h4000_0004, 4'h0, 32'h0, 32'h0000_0055, 1'b1, 1'b0, 1}};
    vecs[3] = '{1'b0, 32'h4000_0009, 32'h0, 4'h0, 2, 1'b0, 32'hCAFE_F00D, 0,
                '{32'h4000_0008, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 3}};
    vecs[4] = '{1'b0, 32'h1000_000C, 32'h0, 4'h0, 20, 1'b0, 32'h7777_7777, 0,
                '{32'h1000_000C, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 8}};
    vecs[5] = '{1'b0, 32'h1000_0000, 32'h0, 4'h0, 7, 1'b0, 32'h0BAD_C0DE, 0,
                '{32'h1000_0000, 4'h0, 32'h0, 32'h0BAD_C0DE, 1'b0, 1'b0, 8}};
    vecs[6] = '{1'b1, 32'h2000_0002, 32'h1122_3344, 4'h0, 1, 1'b0, 32'h9999_9999, 5,
                '{32'h2000_0000, 4'h0, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 2}};
    vecs[7] = '{1'b1, 32'h3000_0021, 32'hFEED_FACE, 4'h5, 9, 1'b0, 32'h0, 2,
                '{32'h3000_0020, 4'h5, 32'hFEED_FACE, 32'h0, 1'b1, 1'b1, 8}};
    vecs[8] = '{1'b1, 32'h3000_0044, 32'h0102_0304, 4'h3, 0, 1'b1, 32'h6666_6666, 0,
                '{32'h3000_0044, 4'h3, 32'h0102_0304, 32'h0, 1'b1, 1'b0, 1}};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset psel", 32'(psel), 32'd0);
    check("reset penable", 32'(penable), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset paddr", paddr, 32'd0);
    rts_n = 1'b1;
    @(negedge clk);
    check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++)
      do_and_check($sformatf("vec%0d", i), vecs[i]);

    // Reset during ACCESS wait states.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h5000_0010;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid setup psel", 32'(psel), 32'd1);
    @(negedge clk);
    check("mid access penable", 32'(penable), 32'd1);
    @(negedge clk);
    rts_n = 1'b0;
    @(negedge clk);
    check("midrst psel", 32'(psel), 32'd0);
    check("midrst penable", 32'(penable), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst cmd_ready", 32'(cmd_ready), 32'd0);
    check("midrst paddr", paddr, 32'd0);
    rts_n = 1'b1;
    @(negedge clk);
    check("midrst release cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst release rsp_valid", 32'(rsp_valid), 32'd0);
    do_and_check("after_reset", vecs[1]);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom);
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.stb   = 4'($urandom);
      v.waits = $urandom_range(0, 10);
      v.err   = ($urandom_range(0, 3) == 0);
      v.rdata = $urandom;
      v.delay = $urandom_range(0, 3);
      v.e     = model(v.wr, v.addr, v.wdata, v.stb, v.waits, v.err, v.rdata);
      do_and_check($sformatf("rnd%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- Generic APB initiator: converts single-beat requests on a valid/ready command port into APB setup/access transactions on the shared bus, and returns read data and status on a valid/ready response port.
- Sits beside the CPU as a second bus master, for a debug loader, DMA, or console-to-bus bridge, ahead of the bus arbiter.
- Drives the same APB signal set the peripherals (sram, uart, timer, intctrl) already answer.

Parameters:
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width (byte strobes = DATA_WIDTH/8)
- TIMEOUT, 256, max ACCESS cycles without pready before abort; 0 disables timeout
- TO_WIDTH, 16, timeout counter width; TIMEOUT must be < 2^TO_WIDTH

Ports:
- clk  in  1  system clock, all logic on rising edge
- rts_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  request present
- cmd_ready  out  1  request accepted when both high
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_stb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes/timeouts)
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  transaction aborted by timeout
- paddr  out  ADDR_WIDTH  APB address
- pdata  out  DATA_WIDTH  APB write data
- prdata  in  DATA_WIDTH  APB read data
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pstb  out  DATA_WIDTH/8  APB byte strobes
- pready  in  1  slave ready
- perr  in  1  slave error, valid with pready

Behaviour:
- Reset (rts_n=0 at a rising edge): state IDLE. All outputs 0 except cmd_ready, which is 1 from the first cycle after reset deasserts. Timeout counter is 0.
- Reset mid-operation: psel/penable drop at that edge with no completion. Any pending response is discarded.
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the command and go to SETUP.
  - paddr gets cmd_addr with bits [1:0] forced to 0.
  - pstb gets cmd_stb for writes and 0 for reads.
  - pdata gets cmd_wdata for writes and 0 for reads.
- SETUP (one cycle): psel=1, penable=0, cmd_ready=0. Next state ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pdata, pwrite and pstb are held stable.
  - Each cycle with pready=0, the counter increments.
  - pready=1: capture prdata (reads only) and perr into rsp_err, rsp_timeout=0, go to RESP.
  - TIMEOUT!=0, counter==TIMEOUT-1 and pready=0: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - pready wins if it coincides with the timeout cycle.
- RESP:
  - psel=0, penable=0, rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_ready, go to IDLE (rsp_valid=0 and cmd_ready=1 next cycle) and clear the counter.
- Latency: command accepted at edge N puts SETUP on the bus in cycle N+1 and ACCESS in N+2. With pready=1 in N+2, rsp_valid=1 in N+3. With rsp_ready held high, cmd_ready is back in N+4, giving a 4-cycle minimum per transaction.
- Exactly one transaction is outstanding; there are no back-to-back APB accesses without an idle cycle.
- perr is ignored when pready=0.
- A write with cmd_stb=0 is still issued on the bus.
- rsp_rdata is 0 on writes.

Decomposition:
- Shared package (apb_pkg): state encoding (IDLE/SETUP/ACCESS/RESP), APB width localparams, and a response-status struct {err, timeout}, also usable by the APB decoder and other masters.
- No sub-module. The timeout counter is inline, in a single module.

Test Plan:
- Write, zero-wait: cmd write addr 0x80000010, data 0xDEADBEEF, stb 0xF, pready=1 in first ACCESS -> psel high 2 cycles, penable 1 cycle, pstb=0xF; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: cmd read addr 0x80000013, slave returns 0x12345678 after 3 cycles of pready=0 -> paddr=0x80000010, pstb=0; ACCESS lasts 4 cycles; rsp_rdata=0x12345678, rsp_err=0.
- Slave error: read with pready=1, perr=1 -> rsp_err=1, rsp_timeout=0; perr=1 while pready=0 is ignored.
- Timeout: TIMEOUT=8, pready held 0 -> exactly 8 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Also check pready=1 on the 8th cycle completes normally.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, no bus activity; cmd_ready=1 the cycle after rsp_ready.
- Reset mid-ACCESS: rts_n=0 for 1 cycle during wait states -> all outputs 0 next edge, no rsp_valid, cmd_ready=1 after release, next command runs normally.
